// File: rtl/flash_arb_pkg.sv
// Shared types for the flash port arbiter: FSM states, the captured request
// bundle and the width of the optional response timeout counter.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } flash_req_t;

  localparam int unsigned TimeoutW = 16;

endpackage

// File: rtl/flash_arb_rr.sv
// Two-way owner pick for the flash arbiter. In round-robin mode a pointer
// names the favoured host on a collision and moves to the other host on every
// grant. A lone requester always wins. FixedPrio != 0 makes host 0 win always.
module flash_arb_rr #(
  parameter int unsigned FixedPrio = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  input  logic       owner_i,
  output logic       pick_o
);

  if (FixedPrio != 0) begin : g_fixed
    // Host 0 wins whenever it is requesting
    always_comb pick_o = !req_i[0];
  end else begin : g_rr
    logic ptr_q;
    logic ptr_d;

    // Pick the pointer host on a collision; point at the non-owner after a grant
    always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
        ptr_d = ~owner_i;
      end
      if (req_i == 2'b11) begin
        pick_o = ptr_q;
      end else begin
        pick_o = req_i[1] & ~req_i[0];
      end
    end

    // Pointer register, host 0 favoured out of reset
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ptr_q <= 1'b0;
      end else begin
        ptr_q <= ptr_d;
      end
    end
  end

endmodule

// File: rtl/flash_port_arbiter.sv
// Arbitrates two host request ports onto one slow flash port with a single
// outstanding transaction. IDLE captures the winner's bundle, ISSUE presents
// it for one accepted cycle (stalled by flash_wait_i), WAIT_RESP forwards the
// response to the owner.
// Optional feature: define FLASH_ARB_TIMEOUT_EN to end WAIT_RESP with an
// error response after TimeoutCycles cycles without flash_rvalid_i.
module flash_port_arbiter
  import flash_arb_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 64,
  parameter int unsigned FixedPrio     = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        h0_req_i,
  input  logic        h0_we_i,
  input  logic [3:0]  h0_be_i,
  input  logic [31:0] h0_addr_i,
  input  logic [31:0] h0_wdata_i,
  output logic        h0_gnt_o,
  output logic        h0_rvalid_o,
  output logic [31:0] h0_rdata_o,
  output logic        h0_err_o,

  input  logic        h1_req_i,
  input  logic        h1_we_i,
  input  logic [3:0]  h1_be_i,
  input  logic [31:0] h1_addr_i,
  input  logic [31:0] h1_wdata_i,
  output logic        h1_gnt_o,
  output logic        h1_rvalid_o,
  output logic [31:0] h1_rdata_o,
  output logic        h1_err_o,

  output logic        flash_req_o,
  output logic        flash_we_o,
  output logic [3:0]  flash_be_o,
  output logic [31:0] flash_addr_o,
  output logic [31:0] flash_wdata_o,
  input  logic        flash_rvalid_i,
  input  logic [31:0] flash_rdata_i,
  input  logic        flash_wait_i
);

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  flash_req_t  bundle_q, bundle_d;

  logic [1:0]  host_req;
  flash_req_t  host_bundle [2];
  logic        pick;
  logic        grant;
  logic        resp_ok;
  logic        resp_to;

  logic [1:0]  gnt_vec;
  logic [1:0]  rvalid_vec;
  logic [1:0]  err_vec;
  logic [31:0] rdata_vec [2];

  // Gather the per-host request bundles into indexable form
  always_comb begin
    host_req       = {h1_req_i, h0_req_i};
    host_bundle[0] = '{we: h0_we_i, be: h0_be_i, addr: h0_addr_i, wdata: h0_wdata_i};
    host_bundle[1] = '{we: h1_we_i, be: h1_be_i, addr: h1_addr_i, wdata: h1_wdata_i};
  end

  // The flash accepts the request in the first ISSUE cycle without wait;
  // responses are only honoured while a transaction is outstanding
  assign grant   = (state_q == ISSUE) && !flash_wait_i;
  assign resp_ok = (state_q == WAIT_RESP) && flash_rvalid_i;

  flash_arb_rr #(
    .FixedPrio (FixedPrio)
  ) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (host_req),
    .advance_i (grant),
    .owner_i   (owner_q),
    .pick_o    (pick)
  );

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TimeoutCycles - 1);

  logic [TimeoutW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter is zero on the first WAIT_RESP cycle; a real response wins the tie
  always_comb begin
    tmo_cnt_d = (state_q == WAIT_RESP) ? tmo_cnt_q + 1'b1 : '0;
  end
  assign resp_to = (state_q == WAIT_RESP) && !flash_rvalid_i && (tmo_cnt_q == TimeoutLast);

  // Timeout counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  // Without the timeout WAIT_RESP waits for the flash indefinitely
  assign resp_to = 1'b0;
`endif

  // Next-state logic: capture in IDLE, issue once, wait for the response
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    bundle_d = bundle_q;
    unique case (state_q)
      IDLE: begin
        if (|host_req) begin
          owner_d  = pick;
          bundle_d = host_bundle[pick];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (grant) begin
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (resp_ok || resp_to) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, owner and captured bundle registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      bundle_q <= bundle_d;
    end
  end

  // Per-host response steering; only the owner ever sees gnt/rvalid/err
  for (genvar gi = 0; gi < 2; gi++) begin : g_host
    logic is_owner;
    assign is_owner       = (owner_q == 1'(gi)) && !rst_i;
    assign gnt_vec[gi]    = is_owner && grant;
    assign rvalid_vec[gi] = is_owner && (resp_ok || resp_to);
    assign err_vec[gi]    = is_owner && resp_to;
    assign rdata_vec[gi]  = (is_owner && resp_ok) ? flash_rdata_i : '0;
  end

  assign h0_gnt_o    = gnt_vec[0];
  assign h0_rvalid_o = rvalid_vec[0];
  assign h0_err_o    = err_vec[0];
  assign h0_rdata_o  = rdata_vec[0];
  assign h1_gnt_o    = gnt_vec[1];
  assign h1_rvalid_o = rvalid_vec[1];
  assign h1_err_o    = err_vec[1];
  assign h1_rdata_o  = rdata_vec[1];

  // Flash port: one accepted request cycle, bundle forced low while in reset
  assign flash_req_o   = grant && !rst_i;
  assign flash_we_o    = bundle_q.we && !rst_i;
  assign flash_be_o    = rst_i ? '0 : bundle_q.be;
  assign flash_addr_o  = rst_i ? '0 : bundle_q.addr;
  assign flash_wdata_o = rst_i ? '0 : bundle_q.wdata;

endmodule
